// File: rtl/key_converter.sv
// ASCII-to-game key code converter: decodes the keyboard byte into a 4-bit code,
// registered, either following the held byte (level) or pulsing once per new byte.
module key_converter #(
   parameter bit CASE_INSENSITIVE = 1'b1,
   parameter bit PULSE_MODE       = 1'b0
) (
   output logic [3:0] key,
   input  logic [7:0] keyboard,
   input  logic       clk,
   input  logic       rst_n
);

   logic [3:0] code;
   logic [3:0] key_d;
   logic [7:0] prev_q;

   // Unknown or unlisted bytes fall to the default, so they never decode as a key.
   always_comb begin
      code = 4'd0;
      case (keyboard)
         8'h57:   code = 4'd1;
         8'h41:   code = 4'd2;
         8'h53:   code = 4'd3;
         8'h44:   code = 4'd4;
         8'h4A:   code = 4'd5;
         8'h4B:   code = 4'd6;
         8'h4C:   code = 4'd7;
         8'h20:   code = 4'd8;
         8'h77:   code = CASE_INSENSITIVE ? 4'd1 : 4'd0;
         8'h61:   code = CASE_INSENSITIVE ? 4'd2 : 4'd0;
         8'h73:   code = CASE_INSENSITIVE ? 4'd3 : 4'd0;
         8'h64:   code = CASE_INSENSITIVE ? 4'd4 : 4'd0;
         8'h6A:   code = CASE_INSENSITIVE ? 4'd5 : 4'd0;
         8'h6B:   code = CASE_INSENSITIVE ? 4'd6 : 4'd0;
         8'h6C:   code = CASE_INSENSITIVE ? 4'd7 : 4'd0;
         default: code = 4'd0;
      endcase
   end

   always_comb begin
      key_d = code;
      if (PULSE_MODE) begin
         key_d = 4'd0;
         if ((code != 4'd0) && (keyboard != prev_q)) begin
            key_d = code;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key    <= 4'd0;
         prev_q <= 8'h00;
      end else begin
         key    <= key_d;
         prev_q <= keyboard;
      end
   end

endmodule

// File: tb/tb_key_converter.sv
// Bench for key_converter: three variants (level, level case-sensitive, pulse) checked
// against a table-driven reference model every cycle plus hand-computed directed vectors.
module tb_key_converter;

   logic       clk;
   logic       rst_n;
   logic [7:0] keyboard;
   logic [3:0] key_lvl;
   logic [3:0] key_cs;
   logic [3:0] key_pls;

   int tests_run;
   int tests_failed;

   key_converter #(.CASE_INSENSITIVE(1'b1), .PULSE_MODE(1'b0)) u_lvl (
      .key(key_lvl), .keyboard(keyboard), .clk(clk), .rst_n(rst_n)
   );
   key_converter #(.CASE_INSENSITIVE(1'b0), .PULSE_MODE(1'b0)) u_cs (
      .key(key_cs), .keyboard(keyboard), .clk(clk), .rst_n(rst_n)
   );
   key_converter #(.CASE_INSENSITIVE(1'b1), .PULSE_MODE(1'b1)) u_pls (
      .key(key_pls), .keyboard(keyboard), .clk(clk), .rst_n(rst_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference decode: position in the key string gives the code; lower case is +0x20.
   function automatic logic [3:0] ref_decode(input logic [7:0] b, input bit ci);
      string keys;
      logic [7:0] ch;
      keys = "WASDJKL ";
      ref_decode = 4'd0;
      for (int i = 0; i < 8; i++) begin
         ch = keys[i];
         if (b === ch) ref_decode = 4'(i + 1);
         if (ci && (i < 7) && (b === (ch + 8'h20))) ref_decode = 4'(i + 1);
      end
   endfunction

   logic [3:0] m_lvl, m_cs, m_pls;
   logic [7:0] m_last;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_lvl  <= 4'd0;
         m_cs   <= 4'd0;
         m_pls  <= 4'd0;
         m_last <= 8'h00;
      end else begin
         m_lvl  <= ref_decode(keyboard, 1'b1);
         m_cs   <= ref_decode(keyboard, 1'b0);
         m_pls  <= (keyboard !== m_last) ? ref_decode(keyboard, 1'b1) : 4'd0;
         m_last <= keyboard;
      end
   end

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("model lvl", key_lvl, m_lvl);
      check("model cs", key_cs, m_cs);
      check("model pls", key_pls, m_pls);
   end

   // {byte, level code, case-sensitive code, pulse code}
   logic [19:0] tbl [29] = '{
      20'h57111, 20'h57110, 20'h41222, 20'h53333, 20'h44444, 20'h4A555, 20'h4B666,
      20'h4C777, 20'h20888, 20'h77101, 20'h6C707, 20'h00000, 20'h42000, 20'h0D000,
      20'hA0000, 20'h20888, 20'h20880, 20'h20880, 20'h20880, 20'h20880, 20'h00000,
      20'h20888, 20'h44444, 20'h44440, 20'hFF000, 20'h80000, 20'h61202, 20'h41222,
      20'h41220
   };

   // Called at posedge+2: drive byte, wait for the edge, check 1 ns after it.
   task automatic step(input logic [7:0] b, input logic [3:0] el, input logic [3:0] ec,
                       input logic [3:0] ep, input string tag);
      keyboard = b;
      @(posedge clk);
      #1;
      check({tag, " lvl"}, key_lvl, el);
      check({tag, " cs"}, key_cs, ec);
      check({tag, " pls"}, key_pls, ep);
      #1;
   endtask

   initial begin
      logic [19:0] v;
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b1;
      keyboard     = 8'h57;
      #1 rst_n = 1'b0;
      #2;
      check("reset lvl", key_lvl, 4'd0);
      check("reset cs", key_cs, 4'd0);
      check("reset pls", key_pls, 4'd0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;

      for (int i = 0; i < 29; i++) begin
         v = tbl[i];
         step(v[19:12], v[11:8], v[7:4], v[3:0], $sformatf("vec%0d", i));
      end

      // Reset arriving mid-pulse must clear key at once and clear the previous byte.
      step(8'h00, 4'd0, 4'd0, 4'd0, "pre-pulse");
      step(8'h20, 4'd8, 4'd8, 4'd8, "pulse");
      rst_n = 1'b0;
      #1;
      check("async lvl", key_lvl, 4'd0);
      check("async pls", key_pls, 4'd0);
      @(posedge clk);
      #1;
      check("held reset pls", key_pls, 4'd0);
      #1 rst_n = 1'b1;
      step(8'h20, 4'd8, 4'd8, 4'd8, "post-reset");
      step(8'h20, 4'd8, 4'd8, 4'd0, "post-reset hold");

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/key_converter.md
Name: key_converter

Overview:
- Translates the 8-bit ASCII byte from the keyboard receiver into the 4-bit key code used by the game state machine.
- Codes: W/A/S/D movement, J/K/L actions, SPACE confirm, 0 idle.
- Sits between the keyboard/UART front end and the game controller.
- Output is registered: one clock latency, asynchronous active-low reset.

Parameters:
- CASE_INSENSITIVE, 1: 1 = upper- and lower-case letters both decode; 0 = only upper-case decodes, lower-case gives 0.
- PULSE_MODE, 0: 0 = level mode (key follows held byte); 1 = key is non-zero for exactly one cycle when a new valid byte arrives.

Ports:
- clk, input, 1: system clock; all state updates on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- key, output, 4: registered key code.
- keyboard, input, 8: ASCII byte, held stable by the receiver until the next byte.
- Declaration order is key, keyboard, clk, rst_n, so existing positional instantiations (key, keyboard, clk) stay valid.

Behaviour:
- Reset: while rst_n = 0, key = 0 and the internal previous-byte register = 0x00, regardless of clk. Deassertion takes effect at the next rising clk edge.
- Decode table (combinational):
  - 0x57 'W' -> 1; 0x41 'A' -> 2; 0x53 'S' -> 3; 0x44 'D' -> 4.
  - 0x4A 'J' -> 5; 0x4B 'K' -> 6; 0x4C 'L' -> 7; 0x20 SPACE -> 8.
  - With CASE_INSENSITIVE = 1, also 0x77 -> 1, 0x61 -> 2, 0x73 -> 3, 0x64 -> 4, 0x6A -> 5, 0x6B -> 6, 0x6C -> 7.
  - Every other byte, including 0x00, decodes to 0. Codes 9-15 are never produced.
- Level mode (PULSE_MODE = 0):
  - Each rising edge, key <= decode(keyboard). Latency is exactly 1 cycle.
  - A held byte gives a constant key.
  - A change from one valid byte to another switches key in 1 cycle with no intermediate 0.
- Pulse mode (PULSE_MODE = 1):
  - Each rising edge, prev <= keyboard.
  - key <= decode(keyboard) if keyboard != prev AND decode(keyboard) != 0; otherwise key <= 0.
  - A held byte therefore gives a single-cycle pulse one cycle after it changes.
  - Re-sending the same byte needs an intervening different byte (e.g. 0x00).
  - The first valid byte after reset pulses, because prev = 0x00.
- Boundaries:
  - Reset asserted mid-pulse forces key = 0 immediately.
  - Bit 7 set (0x80-0xFF) always decodes to 0.
  - A change to an invalid byte in pulse mode gives 0.
- No other outputs; no X propagation. An undefined keyboard input must not be treated as a valid key.

Test Plan:
- Reset: rst_n = 0 with keyboard = 0x57 -> key = 0 asynchronously; release rst_n -> key = 1 after the next rising edge.
- Level sweep: apply 0x57, 0x41, 0x53, 0x44, 0x4A, 0x4B, 0x4C, 0x20, one per cycle -> key = 1, 2, 3, 4, 5, 6, 7, 8, each one cycle later.
- Case handling: apply 0x77, 0x6C -> key = 1, 7 with CASE_INSENSITIVE = 1; key = 0, 0 with CASE_INSENSITIVE = 0.
- Invalid bytes: apply 0x00, 0x42 'B', 0x0D, 0xA0 -> key = 0 for each.
- Pulse mode: hold 0x20 for 5 cycles -> key = 8 for exactly 1 cycle then 0. Then 0x20 -> 0x00 -> 0x20 -> a second single-cycle pulse of 8. Then 0x20 -> 0x44 directly -> a single pulse of 4.
- Asynchronous reset mid-pulse (PULSE_MODE = 1): assert rst_n = 0 between edges while key = 8 -> key = 0 immediately. After release with keyboard still 0x20 -> one pulse of 8, since prev was cleared to 0x00.
